// File: rtl/demux4_stream_if.sv
// Handshake bundle for demux4_stream: one input stream, four output slots.
// slave is the demux side, master is the producer/consumer environment.
interface demux4_stream_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic             v0;
    logic             v1;
    logic             v2;
    logic             v3;
    logic             r0;
    logic             r1;
    logic             r2;
    logic             r3;

    modport slave (
        input  in_valid,
        input  d,
        input  s0,
        input  s1,
        input  r0,
        input  r1,
        input  r2,
        input  r3,
        output in_ready,
        output y0,
        output y1,
        output y2,
        output y3,
        output v0,
        output v1,
        output v2,
        output v3
    );

    modport master (
        output in_valid,
        output d,
        output s0,
        output s1,
        output r0,
        output r1,
        output r2,
        output r3,
        input  in_ready,
        input  y0,
        input  y1,
        input  y2,
        input  y3,
        input  v0,
        input  v1,
        input  v2,
        input  v3
    );
endinterface

// File: rtl/demux4_stream.sv
// 1:4 stream demux: routes d to one of four registered valid/ready slots
// chosen by {s1,s0}; counts accepted beats and remembers the last select.
module demux4_stream #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    demux4_stream_if.slave   bus,
    output logic [CNT_W-1:0] xfer_count,
    output logic [1:0]       last_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    slot_state_e      state_q [4];
    slot_state_e      state_d [4];
    logic [WIDTH-1:0] slot_q  [4];

    logic [3:0] rdy;
    logic [3:0] full;
    logic [3:0] load;
    logic [3:0] drain;
    logic [1:0] sel;
    logic       accept;

    assign rdy = {bus.r3, bus.r2, bus.r1, bus.r0};

    // Select is forced to 0 when idle so an undriven s0/s1 cannot leak X
    assign sel = bus.in_valid ? {bus.s1, bus.s0} : 2'b00;

    always_comb begin
        full = '0;
        for (int i = 0; i < 4; i++) begin
            full[i] = (state_q[i] == FULL);
        end
    end

    assign bus.in_ready = !full[sel] || rdy[sel];
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        load  = '0;
        drain = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
        end
        load[sel] = accept;
        for (int i = 0; i < 4; i++) begin
            drain[i] = full[i] && rdy[i];
            unique case (state_q[i])
                EMPTY: begin
                    if (load[i]) begin
                        state_d[i] = FULL;
                    end
                end
                FULL: begin
                    // A same-cycle reload keeps the slot full: no bubble
                    if (drain[i] && !load[i]) begin
                        state_d[i] = EMPTY;
                    end
                end
                default: state_d[i] = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
                slot_q[i]  <= '0;
            end
            xfer_count <= '0;
            last_sel   <= 2'b00;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
            end
            if (accept) begin
                slot_q[sel] <= bus.d;
                xfer_count  <= xfer_count + CNT_W'(1);
                last_sel    <= sel;
            end
        end
    end

    assign bus.y0 = slot_q[0];
    assign bus.y1 = slot_q[1];
    assign bus.y2 = slot_q[2];
    assign bus.y3 = slot_q[3];
    assign bus.v0 = full[0];
    assign bus.v1 = full[1];
    assign bus.v2 = full[2];
    assign bus.v3 = full[3];

endmodule

// File: tb/tb_demux4_stream.sv
// Directed, table-driven bench for demux4_stream with an 8-bit counter
// instance and a 2-bit counter instance fed identical stimulus.
module tb_demux4_stream;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demux4_stream_if #(.WIDTH(1)) b ();
    demux4_stream_if #(.WIDTH(1)) w ();

    logic [7:0] cnt8;
    logic [1:0] last8;
    logic [1:0] cnt2;
    logic [1:0] last2;

    demux4_stream #(.WIDTH(1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .bus(b),
        .xfer_count(cnt8), .last_sel(last8)
    );

    demux4_stream #(.WIDTH(1), .CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .bus(w),
        .xfer_count(cnt2), .last_sel(last2)
    );

    assign w.in_valid = b.in_valid;
    assign w.d        = b.d;
    assign w.s0       = b.s0;
    assign w.s1       = b.s1;
    assign w.r0       = b.r0;
    assign w.r1       = b.r1;
    assign w.r2       = b.r2;
    assign w.r3       = b.r3;

    typedef struct {
        logic       iv;
        logic       d;
        logic [1:0] sel;
        logic [3:0] r;
        logic       rdy;
        logic [3:0] v;
        logic [3:0] y;
        logic [7:0] cnt;
        logic [1:0] last;
    } vec_t;

    vec_t vt [19];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic check_outs(input string nm, input logic [3:0] v,
                              input logic [3:0] y, input logic [7:0] cnt,
                              input logic [1:0] last);
        chk({nm, ".v"}, int'({b.v3, b.v2, b.v1, b.v0}), int'(v));
        chk({nm, ".y"}, int'({b.y3, b.y2, b.y1, b.y0}), int'(y));
        chk({nm, ".cnt"}, int'(cnt8), int'(cnt));
        chk({nm, ".last"}, int'(last8), int'(last));
        chk({nm, ".cnt2"}, int'(cnt2), int'(cnt[1:0]));
    endtask

    task automatic drive(input logic iv, input logic d, input logic [1:0] sel,
                         input logic [3:0] r);
        b.in_valid = iv;
        b.d        = d;
        {b.s1, b.s0} = sel;
        {b.r3, b.r2, b.r1, b.r0} = r;
    endtask

    initial begin
        // routing sweep, all ready
        vt[0]  = '{1'b1, 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 4'b0001, 8'd1, 2'd0};
        vt[1]  = '{1'b1, 1'b1, 2'd1, 4'b1111, 1'b1, 4'b0010, 4'b0011, 8'd2, 2'd1};
        vt[2]  = '{1'b1, 1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 4'b0111, 8'd3, 2'd2};
        vt[3]  = '{1'b1, 1'b1, 2'd3, 4'b1111, 1'b1, 4'b1000, 4'b1111, 8'd4, 2'd3};
        vt[4]  = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 4'b1111, 8'd4, 2'd3};
        // back-pressure on channel 2, channel 0 still flows
        vt[5]  = '{1'b1, 1'b1, 2'd2, 4'b1011, 1'b1, 4'b0100, 4'b1111, 8'd5, 2'd2};
        vt[6]  = '{1'b1, 1'b0, 2'd2, 4'b1011, 1'b0, 4'b0100, 4'b1111, 8'd5, 2'd2};
        vt[7]  = '{1'b1, 1'b0, 2'd0, 4'b1011, 1'b1, 4'b0101, 4'b1110, 8'd6, 2'd0};
        vt[8]  = '{1'b1, 1'b0, 2'd2, 4'b1111, 1'b1, 4'b0100, 4'b1010, 8'd7, 2'd2};
        vt[9]  = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 4'b1010, 8'd7, 2'd2};
        // streaming to channel 1
        for (int k = 0; k < 8; k++) begin
            logic dk;
            dk = (k % 2 == 0);
            vt[10+k] = '{1'b1, dk, 2'd1, 4'b1111, 1'b1, 4'b0010,
                         {2'b10, dk, 1'b0}, 8'(8 + k), 2'd1};
        end
        vt[18] = '{1'b0, 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0000, 4'b1000, 8'd15, 2'd1};

        drive(1'b0, 1'b0, 2'd0, 4'b0000);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_outs("reset", 4'b0000, 4'b0000, 8'd0, 2'd0);
        chk("reset.rdy", int'(b.in_ready), 1);

        for (int i = 0; i < 19; i++) begin
            drive(vt[i].iv, vt[i].d, vt[i].sel, vt[i].r);
            #1;
            chk($sformatf("vec%0d.rdy", i), int'(b.in_ready), int'(vt[i].rdy));
            @(posedge clk);
            #1;
            check_outs($sformatf("vec%0d", i), vt[i].v, vt[i].y,
                       vt[i].cnt, vt[i].last);
        end

        // fill channels 0 and 3 with stalled consumers
        drive(1'b1, 1'b1, 2'd0, 4'b0000);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 2'd3, 4'b0000);
        @(posedge clk);
        #1;
        check_outs("fill03", 4'b1001, 4'b1001, 8'd17, 2'd3);
        chk("fill03.rdy3", int'(b.in_ready), 0);

        // reset mid-operation; the beat offered on that edge is discarded
        drive(1'b1, 1'b1, 2'd1, 4'b1111);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b1, 2'd3, 4'b0000);
        #1;
        check_outs("midrst", 4'b0000, 4'b0000, 8'd0, 2'd0);
        chk("midrst.rdy", int'(b.in_ready), 1);
        @(posedge clk);
        #1;
        check_outs("after_rst", 4'b1000, 4'b1000, 8'd1, 2'd3);

        // 255 more accepts on channel 0 wrap the 8-bit counter to 0
        drive(1'b1, 1'b0, 2'd0, 4'b0001);
        repeat (255) @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 2'd0, 4'b0001);
        chk("wrap8.cnt", int'(cnt8), 0);
        chk("wrap8.cnt2", int'(cnt2), 0);
        chk("wrap8.v0", int'(b.v0), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
